pkt_ingress: RTL and testbench

- Upstream neighbour of the processing pipeline (parser → matcher → executor controller).
- Accepts a byte-serial packet stream and assembles the first HDR_LEN bytes into a parallel header array that feeds the pipeline's pkt_hdr input.
- Issues a one-cycle start pulse and holds the header stable until the pipeline reports ready.
- Counts total packet length, discards payload bytes beyond the header, and reports per-packet completion.

---
 rtl/pkt_ingress_pkg.sv | 22 ++
 rtl/pkt_ingress_if.sv | 19 +
 rtl/pkt_ingress_hdr_capture.sv | 32 +++
 rtl/pkt_ingress.sv | 155 +++++++++++++++
 tb/tb_pkt_ingress.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_ingress_pkg.sv
// pkt_ingress_pkg
//   Shared types and constants for the packet ingress block: byte type,
//   default header length (the pipeline's header maximum), FSM state
//   encoding and logic TRUE/FALSE.
package pkt_ingress_pkg;

  typedef logic [7:0] byte_t;

  localparam int HDR_MAX_LEN = 64;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_START = 3'd2,
    ST_ACK   = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/pkt_ingress_if.sv
// pkt_ingress_if
//   Byte-serial packet stream with valid/ready handshake.
//   in_valid_i  source -> sink  byte valid
//   in_data_i   source -> sink  byte
//   in_last_i   source -> sink  final byte of a packet
//   in_ready_o  sink -> source  sink accepts a byte this cycle
//   modport master = stream source, modport slave = pkt_ingress side.
interface pkt_ingress_if;
  import pkt_ingress_pkg::*;

  logic  in_valid_i;
  byte_t in_data_i;
  logic  in_last_i;
  logic  in_ready_o;

  modport master (output in_valid_i, in_data_i, in_last_i, input in_ready_o);
  modport slave  (input in_valid_i, in_data_i, in_last_i, output in_ready_o);

endinterface

// File: rtl/pkt_ingress_hdr_capture.sv
// pkt_ingress_hdr_capture
//   Byte-addressed header register array.
//   clk, rst  clock, async active-high reset (array cleared)
//   clr       synchronous clear of the whole array (has priority over we)
//   we, idx   write din into hdr[idx]
//   hdr       header array, index 0 = first byte of the packet
module pkt_ingress_hdr_capture
  import pkt_ingress_pkg::*;
#(
  parameter int HDR_LEN = HDR_MAX_LEN,
  parameter int IDX_W   = $clog2(HDR_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  byte_t                  din,
  output byte_t [HDR_LEN-1:0]    hdr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr <= '0;
    end else if (clr) begin
      hdr <= '0;
    end else if (we) begin
      hdr[idx] <= din;
    end
  end

endmodule

// File: rtl/pkt_ingress.sv
// pkt_ingress
//   Assembles the first HDR_LEN bytes of a byte-serial packet into a
//   parallel header, pulses proc_start_o to the pipeline, holds the header
//   until the pipeline reports ready, and reports packet length/completion.
//   Optional watchdog on the ACK/WAIT phase: macro PKT_INGRESS_WDT_EN
//   (adds parameter WDT_CYCLES).
//   clk, rst       clock, async active-high reset
//   in_if          byte stream (slave side)
//   pkt_hdr_o      header array, index 0 = first byte
//   proc_start_o   start pulse to the pipeline
//   proc_ready_i   pipeline done level
//   pkt_len_o      byte count of the last packet, saturating
//   short_o        last packet shorter than HDR_LEN
//   done_o         one-cycle pulse when the pipeline finishes a packet
//   wdt_err_o      one-cycle watchdog pulse (0 without the watchdog)
//
//   state | meaning
//   IDLE  | header clear, waiting for the first byte
//   RECV  | receiving; bytes past HDR_LEN are counted but dropped
//   START | proc_start_o pulse, length/short valid
//   ACK   | pipeline must drop ready; if still ready, start is re-pulsed
//   WAIT  | header held until proc_ready_i rises
module pkt_ingress
  import pkt_ingress_pkg::*;
#(
  parameter int HDR_LEN    = HDR_MAX_LEN,
`ifdef PKT_INGRESS_WDT_EN
  parameter int WDT_CYCLES = 1024,
`endif
  parameter int LEN_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pkt_ingress_if.slave         in_if,
  output byte_t [HDR_LEN-1:0]  pkt_hdr_o,
  output logic                 proc_start_o,
  input  logic                 proc_ready_i,
  output logic [LEN_W-1:0]     pkt_len_o,
  output logic                 short_o,
  output logic                 done_o,
  output logic                 wdt_err_o
);

  localparam int IDX_W = $clog2(HDR_LEN);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] RECV  = ST_RECV;
  localparam logic [2:0] START = ST_START;
  localparam logic [2:0] ACK   = ST_ACK;
  localparam logic [2:0] WAIT  = ST_WAIT;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_inc, cnt_nxt;
  logic [LEN_W-1:0] len_q;
  logic             short_q, done_q, err_q;
  logic             done_d, err_d, wdt_hit;
  logic             rdy, xfer, hdr_we;
  logic [IDX_W-1:0] hdr_idx;

  // Ready is forced low while rst is held so every output reads 0 in reset.
  assign rdy  = !rst && (state_q == IDLE || state_q == RECV);
  assign xfer = in_if.in_valid_i && rdy;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
  assign cnt_nxt = (state_q == IDLE) ? LEN_W'(1) : cnt_inc;

  assign hdr_we  = xfer && (state_q == IDLE || cnt_q < LEN_W'(HDR_LEN));
  assign hdr_idx = (state_q == IDLE) ? '0 : cnt_q[IDX_W-1:0];

`ifdef PKT_INGRESS_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES) + 1;
  logic [WDT_W-1:0] wdt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q <= '0;
    end else if (state_q == START) begin
      wdt_q <= '0;
    end else if (state_q == ACK || state_q == WAIT) begin
      wdt_q <= wdt_q + WDT_W'(1);
    end
  end

  assign wdt_hit = (state_q == ACK || state_q == WAIT) &&
                   (wdt_q == WDT_W'(WDT_CYCLES - 1));
`else
  assign wdt_hit = FALSE;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = FALSE;
    err_d   = FALSE;
    case (state_q)
      IDLE:    if (xfer) state_d = in_if.in_last_i ? START : RECV;
      RECV:    if (xfer && in_if.in_last_i) state_d = START;
      START:   state_d = ACK;
      ACK:     if (!proc_ready_i) state_d = WAIT;
      WAIT: begin
        if (proc_ready_i) begin
          state_d = IDLE;
          done_d  = TRUE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A real completion in the same cycle wins over the watchdog.
    if (wdt_hit && !done_d) begin
      state_d = IDLE;
      err_d   = TRUE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      short_q <= FALSE;
      done_q  <= FALSE;
      err_q   <= FALSE;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (xfer) cnt_q <= cnt_nxt;
      // Length/short latch with the last byte so they are valid with the pulse.
      if (xfer && in_if.in_last_i) begin
        len_q   <= cnt_nxt;
        short_q <= (cnt_nxt < LEN_W'(HDR_LEN));
      end
    end
  end

  pkt_ingress_hdr_capture #(
    .HDR_LEN (HDR_LEN),
    .IDX_W   (IDX_W)
  ) u_hdr (
    .clk (clk),
    .rst (rst),
    .clr (done_d || err_d),
    .we  (hdr_we),
    .idx (hdr_idx),
    .din (in_if.in_data_i),
    .hdr (pkt_hdr_o)
  );

  assign in_if.in_ready_o = rdy;
  assign proc_start_o     = (state_q == START) || (state_q == ACK && proc_ready_i);
  assign pkt_len_o        = len_q;
  assign short_o          = short_q;
  assign done_o           = done_q;
  assign wdt_err_o        = err_q;

endmodule

// File: tb/tb_pkt_ingress.sv
module tb_pkt_ingress;

  localparam int HDR_LEN = 64;
  localparam int LEN_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proc_ready = 1'b0;
  logic [HDR_LEN-1:0][7:0] hdr;
  logic proc_start, short_b, done_b, wdt_err;
  logic [LEN_W-1:0] pkt_len;

  int checks = 0;
  int errors = 0;

  pkt_ingress_if bus ();

  pkt_ingress #(
    .HDR_LEN    (HDR_LEN),
`ifdef PKT_INGRESS_WDT_EN
    .WDT_CYCLES (16),
`endif
    .LEN_W      (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus.slave),
    .pkt_hdr_o    (hdr),
    .proc_start_o (proc_start),
    .proc_ready_i (proc_ready),
    .pkt_len_o    (pkt_len),
    .short_o      (short_b),
    .done_o       (done_b),
    .wdt_err_o    (wdt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Header must hold bytes base, base+1, ... for the first n slots, zeros after.
  task automatic chk_hdr(input string tag, input int n, input int base);
    logic [7:0] e;
    for (int i = 0; i < HDR_LEN; i++) begin
      e = (i < n) ? 8'(base + i) : 8'h00;
      chk($sformatf("%s[%0d]", tag, i), 32'(hdr[i]), 32'(e));
    end
  endtask

  // Called at a negedge with in_ready high; returns at the START-cycle negedge.
  task automatic send_pkt(input string tag, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ready%0d", tag, i), 32'(bus.in_ready_o), 32'd1);
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 8'(base + i);
      bus.in_last_i  = (i == n - 1);
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  // From WAIT: raise ready, expect done pulse and return to IDLE.
  task automatic finish_pkt(input string tag);
    proc_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, 32'(done_b), 32'd1);
    chk({tag, "_idle_ready"}, 32'(bus.in_ready_o), 32'd1);
    chk({tag, "_hdr_clr"}, 32'(hdr[0]), 32'd0);
    proc_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done_b), 32'd0);
  endtask

  initial begin
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
    bus.in_last_i  = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready_o), 32'd0);
    chk("rst_start", 32'(proc_start), 32'd0);
    chk("rst_len", 32'(pkt_len), 32'd0);
    chk("rst_short", 32'(short_b), 32'd0);
    chk("rst_done", 32'(done_b), 32'd0);
    chk("rst_wdt", 32'(wdt_err), 32'd0);
    chk("rst_hdr0", 32'(hdr[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.in_ready_o), 32'd1);

    // 20-byte packet, ready rises 10 cycles after start
    send_pkt("p20", 20, 1);
    chk("p20_start", 32'(proc_start), 32'd1);
    chk("p20_len", 32'(pkt_len), 32'd20);
    chk("p20_short", 32'(short_b), 32'd1);
    chk("p20_ready_start", 32'(bus.in_ready_o), 32'd0);
    @(negedge clk);
    chk("p20_start_pulse", 32'(proc_start), 32'd0);
    @(negedge clk);
    chk_hdr("p20_hdr", 20, 1);
    for (int k = 0; k < 8; k++) begin
      chk("p20_wait_start", 32'(proc_start), 32'd0);
      chk("p20_wait_done", 32'(done_b), 32'd0);
      @(negedge clk);
    end
    finish_pkt("p20");
    chk("p20_len_hold", 32'(pkt_len), 32'd20);

    // 100-byte packet: bytes past 64 dropped
    send_pkt("p100", 100, 1);
    chk("p100_start", 32'(proc_start), 32'd1);
    chk("p100_len", 32'(pkt_len), 32'd100);
    chk("p100_short", 32'(short_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk_hdr("p100_hdr", 100, 1);
    finish_pkt("p100");

    // Ready held high for 3 cycles after start: start re-pulses in ACK
    send_pkt("pbusy", 3, 8'h30);
    chk("busy_start0", 32'(proc_start), 32'd1);
    proc_ready = 1'b1;
    @(negedge clk);
    chk("busy_start1", 32'(proc_start), 32'd1);
    chk("busy_ready1", 32'(bus.in_ready_o), 32'd0);
    @(negedge clk);
    chk("busy_start2", 32'(proc_start), 32'd1);
    @(negedge clk);
    chk("busy_start3", 32'(proc_start), 32'd1);
    chk("busy_no_done", 32'(done_b), 32'd0);
    proc_ready = 1'b0;
    @(negedge clk);
    chk("busy_wait_start", 32'(proc_start), 32'd0);
    chk("busy_wait_done", 32'(done_b), 32'd0);
    chk("busy_wait_ready", 32'(bus.in_ready_o), 32'd0);
    @(negedge clk);
    chk("busy_wait2_start", 32'(proc_start), 32'd0);
    chk_hdr("busy_hdr", 3, 8'h30);
    finish_pkt("pbusy");

    // Back-to-back with valid held high
    send_pkt("pa", 5, 8'hA0);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 8'hB0;
    chk("b2b_start", 32'(proc_start), 32'd1);
    chk("b2b_ready_start", 32'(bus.in_ready_o), 32'd0);
    @(negedge clk);
    chk("b2b_ready_ack", 32'(bus.in_ready_o), 32'd0);
    @(negedge clk);
    chk("b2b_ready_wait", 32'(bus.in_ready_o), 32'd0);
    chk_hdr("b2b_hdr_a", 5, 8'hA0);
    @(negedge clk);
    chk("b2b_hold0", 32'(hdr[0]), 32'hA0);
    chk("b2b_hold4", 32'(hdr[4]), 32'hA4);
    proc_ready = 1'b1;
    @(negedge clk);
    chk("b2b_done", 32'(done_b), 32'd1);
    chk("b2b_idle_ready", 32'(bus.in_ready_o), 32'd1);
    chk("b2b_clr0", 32'(hdr[0]), 32'd0);
    proc_ready = 1'b0;
    @(negedge clk);
    bus.in_data_i = 8'hB1;
    @(negedge clk);
    bus.in_data_i = 8'hB2;
    bus.in_last_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    chk("b2b_b_start", 32'(proc_start), 32'd1);
    chk("b2b_b_len", 32'(pkt_len), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk_hdr("b2b_hdr_b", 3, 8'hB0);
    finish_pkt("pb");

    // Reset asserted mid-RECV after 7 bytes
    for (int i = 0; i < 7; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 8'(8'h50 + i);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(bus.in_ready_o), 32'd0);
    chk("mrst_start", 32'(proc_start), 32'd0);
    chk("mrst_len", 32'(pkt_len), 32'd0);
    chk("mrst_short", 32'(short_b), 32'd0);
    chk("mrst_done", 32'(done_b), 32'd0);
    chk("mrst_hdr0", 32'(hdr[0]), 32'd0);
    chk("mrst_hdr6", 32'(hdr[6]), 32'd0);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_pkt("pr", 4, 8'h60);
    chk("pr_start", 32'(proc_start), 32'd1);
    chk("pr_len", 32'(pkt_len), 32'd4);
    @(negedge clk);
    @(negedge clk);
    chk_hdr("pr_hdr", 4, 8'h60);
    finish_pkt("pr");

    // Pipeline never answers
    send_pkt("pw", 2, 8'h70);
`ifdef PKT_INGRESS_WDT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("wdt_quiet%0d", k), 32'(wdt_err), 32'd0);
    end
    @(negedge clk);
    chk("wdt_pulse", 32'(wdt_err), 32'd1);
    chk("wdt_no_done", 32'(done_b), 32'd0);
    chk("wdt_ready", 32'(bus.in_ready_o), 32'd1);
    chk("wdt_hdr_clr", 32'(hdr[0]), 32'd0);
    @(negedge clk);
    chk("wdt_pulse_1cyc", 32'(wdt_err), 32'd0);
    chk("wdt_no_done2", 32'(done_b), 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("nowdt_err", 32'(wdt_err), 32'd0);
    end
    chk("nowdt_still_wait", 32'(bus.in_ready_o), 32'd0);
    chk("nowdt_hdr_held", 32'(hdr[1]), 32'h71);
    finish_pkt("pw");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
